// File: rtl/ssd_block_loader.sv
// ssd_block_loader
// Producer side of the SSD block datapath. It fetches one 6-row x 12-column
// pixel window from a pixel BRAM. The first six columns of each row are packed
// into back_buffer and the next six into front_buffer. valid_out pulses for one
// cycle once both buffers are complete.
//
// Ports
//   clk_in        system clock, rising edge
//   rst_in        asynchronous active-low reset
//   start_in      load request, accepted only while ready_out=1
//   block_x_in    leftmost window column (sampled on accept)
//   block_y_in    top window row (sampled on accept)
//   ready_out     high while idle
//   bram_addr_out pixel read address (0 for out-of-bounds slots)
//   bram_dout_in  pixel data, READ_LATENCY cycles after its address
//   back_buffer   row r = columns x..x+5, leftmost pixel in [47:40]
//   front_buffer  row r = columns x+6..x+11, leftmost pixel in [47:40]
//   valid_out     one-cycle pulse when the buffers are complete
module ssd_block_loader #(
   parameter int unsigned IMG_WIDTH    = 240,
   parameter int unsigned IMG_HEIGHT   = 320,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned ADDR_W       = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          start_in,
   input  logic [$clog2(IMG_WIDTH):0]    block_x_in,
   input  logic [$clog2(IMG_HEIGHT):0]   block_y_in,
   output logic                          ready_out,
   output logic [ADDR_W-1:0]             bram_addr_out,
   input  logic [7:0]                    bram_dout_in,
   output logic [5:0][47:0]              back_buffer,
   output logic [5:0][47:0]              front_buffer,
   output logic                          valid_out
);

   localparam int unsigned XW  = $clog2(IMG_WIDTH) + 1;
   localparam int unsigned YW  = $clog2(IMG_HEIGHT) + 1;
   localparam int unsigned AW1 = ADDR_W + 1;

   localparam logic [AW1-1:0]    IMG_W_WIDE = AW1'(IMG_WIDTH);
   localparam logic [AW1-1:0]    IMG_H_WIDE = AW1'(IMG_HEIGHT);
   localparam logic [ADDR_W-1:0] IMG_W_ADDR = ADDR_W'(IMG_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Tag travelling alongside each issued read.
   typedef struct packed {
      logic       valid;
      logic [2:0] row;
      logic [3:0] col;
      logic       oob;
   } tag_t;

   state_t        state_q, state_d;
   logic          accept;
   logic          issue_en;

   logic [XW-1:0] bx_q, bx_sel;
   logic [YW-1:0] by_q, by_sel;
   logic [2:0]    row_q, row_d;
   logic [3:0]    col_q, col_d;
   logic          last_issue;

   logic [AW1-1:0]    x_abs, y_abs;
   logic              oob_d;
   logic [ADDR_W-1:0] addr_lin;

   tag_t          iss_q;
   tag_t          pipe_q [READ_LATENCY];
   tag_t          cap;
   logic          cap_last;
   logic [7:0]    cap_byte;
   logic [2:0]    cap_sel;
   logic [5:0]    cap_lsb;

   assign last_issue = (row_q == 3'd5) && (col_q == 4'd11);
   assign cap        = pipe_q[READ_LATENCY-1];
   assign cap_last   = cap.valid && (cap.row == 3'd5) && (cap.col == 4'd11);

   // State register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      issue_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               accept   = 1'b1;
               issue_en = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: begin
            if (last_issue) begin
               state_d = S_DRAIN;
            end else begin
               issue_en = 1'b1;
            end
         end
         S_DRAIN: begin
            if (cap_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Row-major index of the next read; the accept cycle restarts at (0,0).
   always_comb begin
      row_d = 3'd0;
      col_d = 4'd0;
      if (!accept) begin
         if (col_q == 4'd11) begin
            row_d = row_q + 3'd1;
            col_d = 4'd0;
         end else begin
            row_d = row_q;
            col_d = col_q + 4'd1;
         end
      end
   end

   // Window origin: live inputs on the accept cycle, latched copy afterwards.
   assign bx_sel = accept ? block_x_in : bx_q;
   assign by_sel = accept ? block_y_in : by_q;

   // Bounds check at one bit wider than the address so nothing wraps first.
   always_comb begin
      x_abs    = AW1'(bx_sel) + AW1'(col_d);
      y_abs    = AW1'(by_sel) + AW1'(row_d);
      oob_d    = (x_abs >= IMG_W_WIDE) || (y_abs >= IMG_H_WIDE);
      addr_lin = ADDR_W'(y_abs) * IMG_W_ADDR + ADDR_W'(x_abs);
   end

   // Read issue: address, index counters and handshake outputs
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         bx_q          <= '0;
         by_q          <= '0;
         row_q         <= 3'd0;
         col_q         <= 4'd0;
         bram_addr_out <= '0;
         iss_q         <= '0;
         ready_out     <= 1'b1;
         valid_out     <= 1'b0;
      end else begin
         ready_out <= (state_d == S_IDLE);
         valid_out <= (state_d == S_DONE);
         if (accept) begin
            bx_q <= block_x_in;
            by_q <= block_y_in;
         end
         if (issue_en) begin
            row_q         <= row_d;
            col_q         <= col_d;
            bram_addr_out <= oob_d ? '0 : addr_lin;
            iss_q         <= '{valid: 1'b1, row: row_d, col: col_d, oob: oob_d};
         end else begin
            bram_addr_out <= '0;
            iss_q         <= '0;
         end
      end
   end

   // Tag delay line matching the BRAM read latency
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= iss_q;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   // Byte lane for the returning pixel: column 0 lands in the top byte.
   always_comb begin
      cap_byte = cap.oob ? 8'h00 : bram_dout_in;
      cap_sel  = (cap.col < 4'd6) ? 3'(4'd5 - cap.col) : 3'(4'd11 - cap.col);
      cap_lsb  = {cap_sel, 3'b000};
   end

   // Capture into the window buffers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         back_buffer  <= '0;
         front_buffer <= '0;
      end else if (cap.valid) begin
         if (cap.col < 4'd6) begin
            back_buffer[cap.row][cap_lsb +: 8] <= cap_byte;
         end else begin
            front_buffer[cap.row][cap_lsb +: 8] <= cap_byte;
         end
      end
   end

endmodule

// File: tb/tb_ssd_block_loader.sv
// Directed bench for ssd_block_loader: one instance at READ_LATENCY=2 and one
// at READ_LATENCY=4, each fed by a behavioural BRAM with pixel(x,y)=(x+3y)&0xFF.
module tb_ssd_block_loader;

   localparam int W = 240;
   localparam int H = 320;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start2, start4;
   logic [8:0]        bx;
   logic [9:0]        by;
   logic              ready2, valid2, ready4, valid4;
   logic [16:0]       addr2, addr4;
   logic [7:0]        dout2, dout4;
   logic [5:0][47:0]  back2, front2, back4, front4;
   logic              poison;
   logic [7:0]        d2 [2];
   logic [7:0]        d4 [4];

   int n_checks = 0;
   int n_pass   = 0;
   int vcyc, vcnt, rdy_err, addr_err;

   always #5 clk = ~clk;

   ssd_block_loader #(.READ_LATENCY(2)) u_dut2 (
      .clk_in(clk), .rst_in(rst_n), .start_in(start2),
      .block_x_in(bx), .block_y_in(by), .ready_out(ready2),
      .bram_addr_out(addr2), .bram_dout_in(dout2),
      .back_buffer(back2), .front_buffer(front2), .valid_out(valid2)
   );

   ssd_block_loader #(.READ_LATENCY(4)) u_dut4 (
      .clk_in(clk), .rst_in(rst_n), .start_in(start4),
      .block_x_in(bx), .block_y_in(by), .ready_out(ready4),
      .bram_addr_out(addr4), .bram_dout_in(dout4),
      .back_buffer(back4), .front_buffer(front4), .valid_out(valid4)
   );

   function automatic logic [7:0] pixel(input int x, input int y);
      return 8'((x + 3 * y) & 255);
   endfunction

   // With poison set, address 0 returns junk so oob slots must be zeroed by the DUT.
   function automatic logic [7:0] mem_rd(input logic [16:0] a);
      int ai;
      ai = int'(a);
      if (poison && ai == 0) return 8'hA5;
      return pixel(ai % W, ai / W);
   endfunction

   function automatic logic [47:0] exp_row(input int x0, input int y, input int half);
      logic [47:0] v;
      int xx;
      v = '0;
      for (int i = 0; i < 6; i++) begin
         xx = x0 + 6 * half + i;
         if (xx < W && y < H) v[8*(5-i) +: 8] = pixel(xx, y);
      end
      return v;
   endfunction

   always @(posedge clk) begin
      d2[0] <= mem_rd(addr2);
      d2[1] <= d2[0];
      d4[0] <= mem_rd(addr4);
      for (int k = 1; k < 4; k++) d4[k] <= d4[k-1];
   end
   assign dout2 = d2[1];
   assign dout4 = d4[3];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic check_win(input string tag, input int x, input int y,
                            input logic [5:0][47:0] bb, input logic [5:0][47:0] fb);
      for (int r = 0; r < 6; r++) begin
         check($sformatf("%s back[%0d]", tag, r), 64'(bb[r]), 64'(exp_row(x, y + r, 0)));
         check($sformatf("%s front[%0d]", tag, r), 64'(fb[r]), 64'(exp_row(x, y + r, 1)));
      end
   endtask

   // mode 0: plain fetch, 1: stray start pulses at cycles 10/40, 2: reset at 30..33
   task automatic run2(input int x, input int y, input int mode);
      int idx, xx, yy, ea;
      logic er;
      @(negedge clk);
      bx = 9'(x); by = 10'(y); start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      vcyc = -1; vcnt = 0; rdy_err = 0; addr_err = 0;
      for (int n = 1; n <= 110; n++) begin
         if (mode == 1) start2 = (n == 10 || n == 40);
         if (mode == 2 && n == 30) begin
            rst_n = 1'b0;
            #1;
            check("async rst back", 64'(|back2), 64'(0));
            check("async rst front", 64'(|front2), 64'(0));
            check("async rst addr", 64'(addr2), 64'(0));
            check("async rst ready", 64'(ready2), 64'(1));
         end
         if (mode == 2 && n == 33) rst_n = 1'b1;
         if (valid2) begin
            vcnt++;
            if (vcyc < 0) vcyc = n;
         end
         er = (mode == 2) ? (n >= 30) : (n >= 76);
         if (ready2 !== er) rdy_err++;
         if (n <= 72 && !(mode == 2 && n >= 30)) begin
            idx = n - 1;
            xx  = x + idx % 12;
            yy  = y + idx / 12;
            ea  = (xx >= W || yy >= H) ? 0 : yy * W + xx;
            if (int'(addr2) != ea) addr_err++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int v1, v2, n4v;
      rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0; bx = '0; by = '0; poison = 1'b0;
      repeat (3) @(negedge clk);
      check("reset ready", 64'(ready2), 64'(1));
      check("reset valid", 64'(valid2), 64'(0));
      check("reset addr", 64'(addr2), 64'(0));
      check("reset back", 64'(|back2), 64'(0));
      check("reset front", 64'(|front2), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("ready after reset", 64'(ready2), 64'(1));

      // Origin window
      run2(0, 0, 0);
      check("w00 valid cycle", 64'(vcyc), 64'(75));
      check("w00 valid count", 64'(vcnt), 64'(1));
      check("w00 ready", 64'(rdy_err), 64'(0));
      check("w00 addr", 64'(addr_err), 64'(0));
      check("w00 back0", 64'(back2[0]), 64'(48'h000102030405));
      check("w00 front0", 64'(front2[0]), 64'(48'h060708090A0B));
      check("w00 back1", 64'(back2[1]), 64'(48'h030405060708));
      check_win("w00", 0, 0, back2, front2);

      // Right edge: x 234..239 in range, front half all oob
      poison = 1'b1;
      run2(234, 10, 0);
      check("redge valid cycle", 64'(vcyc), 64'(75));
      check("redge addr", 64'(addr_err), 64'(0));
      check("redge back0", 64'(back2[0]), 64'(48'h08090A0B0C0D));
      check("redge front zero", 64'(|front2), 64'(0));
      check_win("redge", 234, 10, back2, front2);

      // Bottom edge: rows y=320,321 oob
      run2(0, 316, 0);
      check("bedge valid cycle", 64'(vcyc), 64'(75));
      check("bedge addr", 64'(addr_err), 64'(0));
      check("bedge back0", 64'(back2[0]), 64'(48'hB4B5B6B7B8B9));
      check("bedge rows45", 64'(|{back2[5], back2[4], front2[5], front2[4]}), 64'(0));
      check_win("bedge", 0, 316, back2, front2);

      // Window entirely past the right edge
      run2(300, 5, 0);
      check("xoob valid cycle", 64'(vcyc), 64'(75));
      check("xoob addr", 64'(addr_err), 64'(0));
      check("xoob back zero", 64'(|back2), 64'(0));
      check("xoob front zero", 64'(|front2), 64'(0));

      // Stray start pulses mid-fetch are ignored
      poison = 1'b0;
      run2(0, 0, 1);
      check("poke valid cycle", 64'(vcyc), 64'(75));
      check("poke valid count", 64'(vcnt), 64'(1));
      check("poke ready", 64'(rdy_err), 64'(0));
      check_win("poke", 0, 0, back2, front2);

      // Reset mid-fetch abandons the window, then a fresh fetch works
      run2(0, 0, 2);
      check("abort valid count", 64'(vcnt), 64'(0));
      check("abort ready", 64'(rdy_err), 64'(0));
      run2(6, 0, 0);
      check("w60 valid cycle", 64'(vcyc), 64'(75));
      check("w60 back0", 64'(back2[0]), 64'(48'h060708090A0B));
      check_win("w60", 6, 0, back2, front2);

      // Start held high at READ_LATENCY=4: back-to-back windows
      @(negedge clk);
      bx = 9'd0; by = 10'd0; start4 = 1'b1;
      v1 = -1; v2 = -1; n4v = 0;
      for (int n = 1; n <= 170; n++) begin
         @(negedge clk);
         if (n == 2) begin bx = 9'd12; by = 10'd1; end
         if (n == 80) begin bx = 9'd99; by = 10'd99; end
         if (valid4) begin
            n4v++;
            if (v1 < 0) v1 = n;
            else if (v2 < 0) v2 = n;
            if (n == 77) check_win("hold w0", 0, 0, back4, front4);
            if (n == 155) check_win("hold w1", 12, 1, back4, front4);
         end
         if (n == 78) check("hold ready78", 64'(ready4), 64'(1));
         if (n == 155) start4 = 1'b0;
         if (n == 165) check("hold idle ready", 64'(ready4), 64'(1));
      end
      check("hold first valid", 64'(v1), 64'(77));
      check("hold second valid", 64'(v2), 64'(155));
      check("hold valid count", 64'(n4v), 64'(2));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
